// File: rtl/seg_display_driver.sv
// 4-digit multiplexed seven-segment driver: seconds on the right pair, score on the left pair.
// Sequential double-dabble converts both values in 18 cycles. The seconds digits blink after time_up.
module seg_display_driver #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seconds,
    input  logic [7:0] score,
    input  logic       time_up,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       valid
);

    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {LOAD, SHIFT_A, SHIFT_B, COMMIT} state_t;

    state_t state, state_next;
    logic   do_load, do_shift_a, do_shift_b, do_commit;

    logic [2:0] bit_cnt;
    logic [7:0] sec_bin, sco_bin;
    logic [7:0] sec_bcd, sco_bcd;
    logic [7:0] sec_adj, sco_adj;
    logic [3:0] sec_tens, sec_ones, sco_tens, sco_ones;

    logic [SCAN_W-1:0]  scan_cnt;
    logic [1:0]         scan_idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic [6:0]         seg_next;

    function automatic logic [7:0] dd_adjust(input logic [7:0] b);
        logic [3:0] hi, lo;
        hi = (b[7:4] >= 4'd5) ? b[7:4] + 4'd3 : b[7:4];
        lo = (b[3:0] >= 4'd5) ? b[3:0] + 4'd3 : b[3:0];
        return {hi, lo};
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    state_next = SHIFT_A;
            SHIFT_A: if (bit_cnt == 3'd7) state_next = SHIFT_B;
            SHIFT_B: if (bit_cnt == 3'd7) state_next = COMMIT;
            COMMIT:  state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_comb begin
        do_load    = 1'b0;
        do_shift_a = 1'b0;
        do_shift_b = 1'b0;
        do_commit  = 1'b0;
        case (state)
            LOAD:    do_load    = 1'b1;
            SHIFT_A: do_shift_a = 1'b1;
            SHIFT_B: do_shift_b = 1'b1;
            COMMIT:  do_commit  = 1'b1;
            default: do_load    = 1'b1;
        endcase
    end

    assign sec_adj = dd_adjust(sec_bcd);
    assign sco_adj = dd_adjust(sco_bcd);

    // Inputs are clamped once at capture so a change mid-conversion cannot corrupt it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= 3'd0;
            sec_bin  <= 8'd0;
            sco_bin  <= 8'd0;
            sec_bcd  <= 8'd0;
            sco_bcd  <= 8'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            sco_tens <= 4'd0;
            sco_ones <= 4'd0;
            valid    <= 1'b0;
        end else begin
            if (do_load) begin
                sec_bin <= (seconds > 8'd99) ? 8'd99 : seconds;
                sco_bin <= (score > 8'd99) ? 8'd99 : score;
                sec_bcd <= 8'd0;
                sco_bcd <= 8'd0;
                bit_cnt <= 3'd0;
            end
            if (do_shift_a) begin
                sec_bcd <= {sec_adj[6:0], sec_bin[7]};
                sec_bin <= {sec_bin[6:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (do_shift_b) begin
                sco_bcd <= {sco_adj[6:0], sco_bin[7]};
                sco_bin <= {sco_bin[6:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (do_commit) begin
                sec_tens <= sec_bcd[7:4];
                sec_ones <= sec_bcd[3:0];
                sco_tens <= sco_bcd[7:4];
                sco_ones <= sco_bcd[3:0];
                valid    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_idx <= 2'd0;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            scan_idx <= scan_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Held at zero while time is running so the first half-period after time_up is visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!time_up) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_comb begin
        seg_next = 7'b1111111;
        if (valid) begin
            case (scan_idx)
                2'd0:    if (!blink_phase) seg_next = seg_decode(sec_ones);
                2'd1:    if (!blink_phase) seg_next = seg_decode(sec_tens);
                2'd2:    seg_next = seg_decode(sco_ones);
                default: if (sco_tens != 4'd0) seg_next = seg_decode(sco_tens);
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << scan_idx);
            seg <= seg_next;
            dp  <= (scan_idx != 2'd2);
        end
    end

endmodule

// File: tb/tb_seg_display_driver.sv
// Randomized and directed bench for seg_display_driver, checked against a cycle-count reference model.
module tb_seg_display_driver;

    localparam int S = 4;
    localparam int B = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] seconds = 8'd0;
    logic [7:0] score = 8'd0;
    logic       time_up = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       valid;

    always #5 clk = ~clk;

    seg_display_driver #(.SCAN_DIV(S), .BLINK_DIV(B)) dut (
        .clk(clk), .rst(rst), .seconds(seconds), .score(score), .time_up(time_up),
        .an(an), .seg(seg), .dp(dp), .valid(valid)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Model: edges since reset release, consecutive time_up edges, loaded and displayed values.
    int m_n, m_tu, m_ls, m_lc, m_ds, m_dc;
    logic [6:0] font [10];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp, exp_valid;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 99) ? 99 : v;
    endfunction

    task automatic model_reset;
        m_n = 0; m_tu = 0; m_ls = 0; m_lc = 0; m_ds = 0; m_dc = 0;
    endtask

    task automatic step;
        int idx;
        bit blink, vprev;
        @(posedge clk);
        idx   = (m_n / S) % 4;
        blink = ((m_tu / B) % 2) == 1;
        vprev = (m_n >= 18);
        exp_an = 4'b1111;
        exp_an[idx] = 1'b0;
        exp_dp  = (idx != 2);
        exp_seg = 7'b1111111;
        if (vprev) begin
            case (idx)
                0:       if (!blink) exp_seg = font[m_ds % 10];
                1:       if (!blink) exp_seg = font[m_ds / 10];
                2:       exp_seg = font[m_dc % 10];
                default: if (m_dc / 10 != 0) exp_seg = font[m_dc / 10];
            endcase
        end
        m_n++;
        if (m_n % 18 == 1) begin
            m_ls = sat(int'(seconds));
            m_lc = sat(int'(score));
        end
        if (m_n % 18 == 0) begin
            m_ds = m_ls;
            m_dc = m_lc;
        end
        m_tu = time_up ? m_tu + 1 : 0;
        exp_valid = (m_n >= 18);
        @(negedge clk);
        check_eq("an", 32'(an), 32'(exp_an));
        check_eq("seg", 32'(seg), 32'(exp_seg));
        check_eq("dp", 32'(dp), 32'(exp_dp));
        check_eq("valid", 32'(valid), 32'(exp_valid));
    endtask

    task automatic check_reset_values;
        check_eq("rst_an", 32'(an), 32'hF);
        check_eq("rst_seg", 32'(seg), 32'h7F);
        check_eq("rst_dp", 32'(dp), 32'h1);
        check_eq("rst_valid", 32'(valid), 32'h0);
    endtask

    // Called at a falling edge: reset asserts between edges, is checked at once, releases a cycle later.
    task automatic pulse_reset;
        #2 rst = 1'b1;
        #1 check_reset_values();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        font[0] = 7'b1000000; font[1] = 7'b1111001; font[2] = 7'b0100100;
        font[3] = 7'b0110000; font[4] = 7'b0011001; font[5] = 7'b0010010;
        font[6] = 7'b0000010; font[7] = 7'b1111000; font[8] = 7'b0000000;
        font[9] = 7'b0010000;
        model_reset();

        #1 rst = 1'b1;
        #1 check_reset_values();
        seconds = 8'd59;
        score   = 8'd7;
        @(negedge clk);
        rst = 1'b0;
        repeat (60) step();

        seconds = 8'd100;
        score   = 8'd150;
        repeat (40) step();

        seconds = 8'd59;
        score   = 8'd7;
        repeat (40) step();
        while (m_n % 18 != 11) step();
        seconds = 8'd58;
        repeat (40) step();

        seconds = 8'd0;
        time_up = 1'b1;
        repeat (40) step();
        time_up = 1'b0;
        repeat (12) step();

        while (m_n % 18 != 4) step();
        pulse_reset();
        seconds = 8'd23;
        score   = 8'd45;
        repeat (40) step();

        repeat (500) begin
            if ($urandom_range(0, 9) == 0)   seconds = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0)   score   = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0)  time_up = ~time_up;
            if ($urandom_range(0, 299) == 0) pulse_reset();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/seg_display_driver.md
Name: seg_display_driver

Overview:
- Downstream consumer of the 60 s countdown timer's `seconds` and `scoreZero` outputs. Drives the board's 4-digit, common-anode, multiplexed seven-segment display.
- The right digit pair shows seconds remaining. The left pair shows the game score.
- Binary values are converted to BCD by a sequential double-dabble FSM. The seconds digits blink once time is up.

Parameters:
- SCAN_DIV, 100000: clk cycles each digit stays selected (1 kHz per digit at 100 MHz).
- BLINK_DIV, 50000000: clk cycles per blink half-period while time_up is high.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- seconds  input  8  binary seconds remaining, from the countdown counter
- score  input  8  binary game score
- time_up  input  1  high when the countdown has reached zero (counter's scoreZero)
- an  output  4  digit anodes, active-low, one-hot
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- valid  output  1  high once the first BCD conversion has been committed

Behaviour:
- Reset (asynchronous, active-high) forces these values immediately:
  - Outputs: an=4'b1111, seg=7'b1111111, dp=1, valid=0.
  - Internal state: digit registers=0, scan index=0, scan and blink counters=0, FSM=LOAD.
- All outputs are registered.
- Saturation: any input value >99 is clamped to 99 before conversion.
- Conversion FSM states, repeating LOAD -> SHIFT_A -> SHIFT_B -> COMMIT -> LOAD:
  - LOAD (1 cycle): capture saturated seconds and score; clear the BCD shift registers.
  - SHIFT_A (8 cycles): double-dabble on seconds. Each cycle, add 3 to any BCD nibble >=5, then shift left by 1 bringing in the binary MSB.
  - SHIFT_B (8 cycles): same operation on score.
  - COMMIT (1 cycle): copy tens and ones of both values into the display digit registers; set valid=1 (sticky until reset).
- Latency: 18 cycles from LOAD capture to the digit registers updating. An input change is displayed within 36 cycles.
- Inputs that change during SHIFT_A or SHIFT_B do not affect the conversion in progress.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1. When it wraps, the scan index increments 0->1->2->3->0.
  - Each index is held for exactly SCAN_DIV cycles.
  - an = ~(4'b0001 << index), registered.
- Digit mapping by scan index:
  - 0: seconds ones.
  - 1: seconds tens, always shown, including a leading 0.
  - 2: score ones; dp=0 on this index only, dp=1 otherwise.
  - 3: score tens; blanked (seg=7'b1111111) when zero.
- Seven-segment decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Blink:
  - While time_up=1, blink_cnt counts 0..BLINK_DIV-1 and toggles blink_phase each time it wraps.
  - While blink_phase=1, indices 0 and 1 show seg=7'b1111111; their anodes still scan normally.
  - While time_up=0, blink_cnt=0 and blink_phase=0, so the first half-period after time_up rises is visible.
  - Score digits are never blanked by blink.
- Before valid=1, seg stays 7'b1111111 on all indices; an scans normally.
- Reset mid-conversion: the FSM returns to LOAD and valid clears. The first commit after release occurs 18 cycles after reset deassertion.

Test Plan:
- Run with SCAN_DIV=4 and BLINK_DIV=8 for all scenarios.
- Reset: assert rst asynchronously between clock edges -> an=1111, seg=1111111, dp=1, valid=0 immediately; valid rises exactly 18 cycles after release.
- seconds=59, score=7 -> after valid:
  - index0: an=1110, seg=0010000.
  - index1: an=1101, seg=0010010.
  - index2: an=1011, seg=1111000, dp=0.
  - index3: an=0111, seg=1111111.
  - Each index lasts exactly 4 cycles and the scan wraps 3->0.
- score=150, seconds=100 -> both pairs display 99; index3 seg=0010000.
- Change seconds 59->58 during SHIFT_B -> the display shows 58 no later than 36 cycles after the change; an intermediate value never appears.
- seconds=0, time_up 0->1 -> indices 0 and 1 show 1000000 for 8 cycles, then blank for 8 cycles, repeating; score digits stay steady; time_up->0 restores a steady display immediately.
- rst pulse during SHIFT_A -> outputs return to reset values; conversion restarts from LOAD; correct digits appear after 18 cycles.
